// File: rtl/hdlc_pkg.sv
// hdlc_pkg: shared HDLC line constants and transmit FSM states.
package hdlc_pkg;
   localparam logic [7:0] HDLC_FLAG  = 8'h7E;
   localparam logic [7:0] HDLC_ABORT = 8'hFE;
   typedef enum logic [2:0] {IDLE, OPEN, DATA, CLOSE, ABORT} tx_state_t;
endpackage

// File: rtl/hdlc_zero_inserter.sv
// hdlc_zero_inserter: counts consecutive data ones and flags when a zero must be inserted.
module hdlc_zero_inserter
   import hdlc_pkg::*;
#(
   parameter int STUFF_LIMIT = 5
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clear,
   input  logic enable,
   input  logic bit_in,
   output logic hold,
   output logic hold_next
);
   localparam int W = $clog2(STUFF_LIMIT + 1);
   logic [W-1:0] count, count_next;
   // an inserted zero (emitted while hold is set) clears the run just like a data zero
   always_comb count_next = clear ? '0 : !enable ? count : (hold || !bit_in) ? '0 : count + 1'b1;
   assign hold      = count == W'(STUFF_LIMIT);
   assign hold_next = count_next == W'(STUFF_LIMIT);
   always_ff @(posedge Clk or negedge Rst)
      if (!Rst) count <= '0;
      else count <= count_next;
endmodule

// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: serial HDLC transmitter with flags, zero insertion, abort and idle fill.
module hdlc_tx_framer
   import hdlc_pkg::*;
#(
   parameter int OPEN_FLAGS  = 1,
   parameter int STUFF_LIMIT = 5
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] Tx_DataIn,
   input  logic       Tx_DataValid,
   input  logic       Tx_DataLast,
   output logic       Tx_DataReady,
   input  logic       Tx_AbortFrame,
   output logic       Tx,
   output logic       Tx_ValidFrame,
   output logic       Tx_AbortedTrans,
   output logic       Tx_Done
);
   tx_state_t state;
   logic [7:0] sh;
   logic [2:0] bit_cnt, nb;
   logic [1:0] flag_cnt;
   logic last, hs, byte_end, opn_end, go_abort, en, bit_in, hold, hold_next;
   assign nb       = bit_cnt + 3'd1;
   assign hs       = Tx_DataValid && Tx_DataReady && !Tx_AbortFrame;
   assign byte_end = state == DATA && bit_cnt == 3'd7 && !hold;
   assign opn_end  = state == OPEN && bit_cnt == 3'd7 && flag_cnt == 2'(OPEN_FLAGS - 1);
   assign go_abort = (state == OPEN || state == DATA) &&
                     (Tx_AbortFrame || ((opn_end || (byte_end && !last)) && !hs));
   assign en       = hs || (state == DATA && !Tx_AbortFrame && !byte_end);
   assign bit_in   = hs ? Tx_DataIn[0] : sh[nb];
   hdlc_zero_inserter #(.STUFF_LIMIT(STUFF_LIMIT)) u_zi (
      .Clk(Clk), .Rst(Rst), .clear(!en), .enable(en), .bit_in(bit_in),
      .hold(hold), .hold_next(hold_next)
   );
   // every branch decides the bit for the next cycle, so all outputs stay registered
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         sh <= '0;
         bit_cnt <= '0;
         flag_cnt <= '0;
         last <= 1'b0;
         Tx <= 1'b1;
         Tx_ValidFrame <= 1'b0;
         Tx_DataReady <= 1'b0;
         Tx_AbortedTrans <= 1'b0;
         Tx_Done <= 1'b0;
      end else begin
         Tx_AbortedTrans <= 1'b0;
         Tx_Done <= 1'b0;
         if (go_abort) begin
            state <= ABORT;
            bit_cnt <= '0;
            Tx <= HDLC_ABORT[0];
            Tx_ValidFrame <= 1'b0;
            Tx_AbortedTrans <= 1'b1;
            Tx_DataReady <= 1'b0;
         end else if (hs) begin
            state <= DATA;
            sh <= Tx_DataIn;
            last <= Tx_DataLast;
            bit_cnt <= '0;
            Tx <= Tx_DataIn[0];
            Tx_DataReady <= 1'b0;
         end else begin
            case (state)
               IDLE: if (Tx_DataValid) begin
                  state <= OPEN;
                  bit_cnt <= '0;
                  flag_cnt <= '0;
                  Tx <= HDLC_FLAG[0];
                  Tx_ValidFrame <= 1'b1;
               end
               OPEN: begin
                  bit_cnt <= nb;
                  Tx <= HDLC_FLAG[nb];
                  flag_cnt <= bit_cnt == 3'd7 ? flag_cnt + 2'd1 : flag_cnt;
                  Tx_DataReady <= nb == 3'd7 && flag_cnt == 2'(OPEN_FLAGS - 1);
               end
               DATA: if (hold) begin
                  Tx <= 1'b0;
                  Tx_DataReady <= bit_cnt == 3'd7 && !last;
               end else if (bit_cnt != 3'd7) begin
                  bit_cnt <= nb;
                  Tx <= sh[nb];
                  Tx_DataReady <= nb == 3'd7 && !hold_next && !last;
               end else begin
                  state <= CLOSE;
                  bit_cnt <= '0;
                  Tx <= HDLC_FLAG[0];
               end
               CLOSE: if (bit_cnt != 3'd7) begin
                  bit_cnt <= nb;
                  Tx <= HDLC_FLAG[nb];
               end else begin
                  state <= IDLE;
                  Tx <= 1'b1;
                  Tx_ValidFrame <= 1'b0;
                  Tx_Done <= 1'b1;
               end
               ABORT: if (bit_cnt != 3'd7) begin
                  bit_cnt <= nb;
                  Tx <= HDLC_ABORT[nb];
               end else begin
                  state <= IDLE;
                  Tx <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb_hdlc_tx_framer: directed frames with a bit-level scoreboard on Tx and frame events.
module tb_hdlc_tx_framer;
   logic Clk = 1'b0, Rst = 1'b0;
   logic [7:0] Tx_DataIn = '0;
   logic Tx_DataValid = 1'b0, Tx_DataLast = 1'b0, Tx_AbortFrame = 1'b0;
   logic Tx_DataReady, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done;
   int checks = 0, errors = 0;
   logic exp_q[$];
   byte ev_q[$];
   logic [7:0] bq[$];
   int ab_left = 0, vf_len = 0, last_len = 0;

   hdlc_tx_framer dut (
      .Clk(Clk), .Rst(Rst), .Tx_DataIn(Tx_DataIn), .Tx_DataValid(Tx_DataValid),
      .Tx_DataLast(Tx_DataLast), .Tx_DataReady(Tx_DataReady), .Tx_AbortFrame(Tx_AbortFrame),
      .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame), .Tx_AbortedTrans(Tx_AbortedTrans), .Tx_Done(Tx_Done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   task automatic push(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == "1");
   endtask

   task automatic pop_ev(input byte c);
      if (ev_q.size() == 0) chk("unexpected_event", int'(c), 0);
      else chk("event", int'(c), int'(ev_q.pop_front()));
   endtask

   // monitor: every frame or abort-pattern bit on the line is matched against the queue
   always @(negedge Clk) begin
      if (!Rst) begin
         ab_left = 0;
         vf_len = 0;
      end else begin
         if (Tx_AbortedTrans) begin
            ab_left = 8;
            chk("vf_low_on_abort", int'(Tx_ValidFrame), 0);
            pop_ev("A");
         end
         if (Tx_Done) pop_ev("D");
         if (Tx_ValidFrame || ab_left > 0) begin
            if (exp_q.size() == 0) chk("unexpected_bit", int'(Tx), 2);
            else chk("tx_bit", int'(Tx), int'(exp_q.pop_front()));
            if (ab_left > 0) ab_left--;
         end
         if (Tx_ValidFrame) vf_len++;
         else if (vf_len != 0) begin
            last_len = vf_len;
            vf_len = 0;
         end
      end
   end

   task automatic wait_ready();
      for (int n = 0; n < 100; n++) begin
         @(negedge Clk);
         if (Tx_DataReady) return;
      end
      chk("ready_timeout", 0, 1);
   endtask

   // offers every byte in bq; the final one carries Last when last_final is set
   task automatic send(input bit last_final);
      for (int i = 0; i < bq.size(); i++) begin
         Tx_DataIn = bq[i];
         Tx_DataLast = last_final && i == bq.size() - 1;
         Tx_DataValid = 1'b1;
         wait_ready();
         @(posedge Clk);
         #1;
      end
      Tx_DataValid = 1'b0;
      Tx_DataLast = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 400) begin
         @(negedge Clk);
         n++;
      end
      if (exp_q.size() != 0 || ev_q.size() != 0) begin
         chk("drain_timeout", exp_q.size() + ev_q.size(), 0);
         exp_q.delete();
         ev_q.delete();
      end
      repeat (2) @(negedge Clk);
   endtask

   task automatic chk_reset_outputs(input string n);
      chk({n, "_tx"}, int'(Tx), 1);
      chk({n, "_vf"}, int'(Tx_ValidFrame), 0);
      chk({n, "_ready"}, int'(Tx_DataReady), 0);
      chk({n, "_aborted"}, int'(Tx_AbortedTrans), 0);
      chk({n, "_done"}, int'(Tx_Done), 0);
   endtask

   initial begin
      #12;
      chk_reset_outputs("reset");
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      repeat (3) @(negedge Clk);
      chk("idle_tx", int'(Tx), 1);

      push("01111110"); push("10100101"); push("01111110"); ev_q.push_back("D");
      bq = {8'hA5}; send(1); wait_idle();

      push("01111110"); push("111110111"); push("01111110"); ev_q.push_back("D");
      bq = {8'hFF}; send(1); wait_idle();
      chk("ff_frame_len", last_len, 25);

      push("01111110"); push("011111010"); push("10000000"); push("01111110"); ev_q.push_back("D");
      bq = {8'h7E, 8'h01}; send(1); wait_idle();

      push("01111110"); push("10001000"); push("0100"); push("01111111"); ev_q.push_back("A");
      bq = {8'h11, 8'h22}; send(0);
      repeat (3) @(posedge Clk);
      #1 Tx_AbortFrame = 1'b1;
      @(posedge Clk);
      #1 Tx_AbortFrame = 1'b0;
      wait_idle();
      chk("tx_idle_after_abort", int'(Tx), 1);

      push("01111110"); push("11110000"); push("01111111"); ev_q.push_back("A");
      bq = {8'h0F}; send(0); wait_idle();
      chk("tx_idle_after_underflow", int'(Tx), 1);

      push("01111110"); push("111");
      bq = {8'hFF}; send(1);
      repeat (3) @(negedge Clk);
      #2 Rst = 1'b0;
      #1 chk_reset_outputs("midframe_reset");
      chk("reset_leftover_bits", exp_q.size(), 0);
      exp_q.delete();
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      repeat (2) @(negedge Clk);
      chk("tx_after_release", int'(Tx), 1);

      push("01111110"); push("011111000"); push("01111110"); ev_q.push_back("D");
      bq = {8'h3E}; send(1); wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hdlc_tx_framer.md
# hdlc_tx_framer

Serial HDLC transmit framer: accepts payload bytes over a valid/ready handshake and emits one line bit per Clk on Tx. Handles opening/closing flag generation, zero insertion, abort generation and idle fill. Sits in the Tx path of the HDLC core, opposite the Rx deframer, and drives the same Tx, Tx_ValidFrame, Tx_AbortFrame and Tx_AbortedTrans signals that the HDLC assertion module checks.

## Interface
- OPEN_FLAGS, default 1: number of back-to-back opening flags per frame (1..4).
- STUFF_LIMIT, default 5: number of consecutive data 1s after which a 0 is inserted.
- Clk  in  1  system clock, one line bit per cycle.
- Rst  in  1  asynchronous, active-low reset.
- Tx_DataIn  in  8  payload byte, sent LSB first.
- Tx_DataValid  in  1  Tx_DataIn is valid.
- Tx_DataLast  in  1  qualifies Tx_DataIn as the final byte of the frame.
- Tx_DataReady  out  1  byte accepted when Tx_DataValid && Tx_DataReady.
- Tx_AbortFrame  in  1  request to abort the current frame; level-sampled.
- Tx  out  1  serial line, registered.
- Tx_ValidFrame  out  1  high while flags or data of a frame are on Tx.
- Tx_AbortedTrans  out  1  one-cycle pulse when the abort pattern starts.
- Tx_Done  out  1  one-cycle pulse when a frame completes normally.

## Operation
- Reset values: Tx=1, Tx_ValidFrame=0, Tx_DataReady=0, Tx_AbortedTrans=0, Tx_Done=0, state IDLE, ones counter 0.
- **IDLE**
  - Tx=1, which forms the idle pattern.
  - Tx_DataValid sampled high moves the block to OPEN. The byte is not consumed.
- **OPEN**
  - Sends OPEN_FLAGS × 0x7E, LSB first, so each flag is 0,1,1,1,1,1,1,0. Flags are never stuffed.
  - Tx_DataReady is high during the last flag bit cycle.
  - On handshake, go to DATA. Without a handshake, go to ABORT (underflow).
- **DATA**
  - Shifts the byte out LSB first.
  - The ones counter increments on each data 1 and clears on each data 0, each inserted 0, and each flag.
  - When the counter reaches STUFF_LIMIT, the next bit time carries an inserted 0 and the shift register holds.
  - The counter carries across byte boundaries.
  - Tx_DataReady is high during the final bit time of the current byte. If the byte's last data bit triggers a stuff, that final bit time is the trailing inserted 0.
  - A handshake at that point loads the next byte with no gap.
  - No handshake, with the current byte not Last, goes to ABORT.
  - Current byte Last goes to CLOSE, and Tx_DataReady stays low.
- **CLOSE**
  - Sends one 0x7E, then goes to IDLE.
  - Tx_Done pulses in the first IDLE cycle.
  - At least one idle 1 always follows before the next frame.
- **ABORT**
  - Sends 0 followed by seven 1s, then goes to IDLE.
  - Tx_AbortedTrans pulses in the cycle the 0 is on Tx.
  - Tx_ValidFrame goes low in that same cycle.
- **Abort request**
  - Tx_AbortFrame high in OPEN or DATA: the current bit time completes, then ABORT starts on the next cycle.
  - Pending data is discarded and Tx_DataReady is forced low.
  - Tx_AbortFrame is ignored in IDLE, CLOSE and ABORT.
  - If an abort request and a handshake occur in the same cycle, the abort wins and the byte is not consumed.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). No closing flag or abort pattern is sent.

## Timing
- Tx_DataValid rises in IDLE at cycle N: first flag bit (0) on Tx at N+1, with Tx_ValidFrame=1 at N+1.
- With OPEN_FLAGS=1: Tx_DataReady at N+8, first data bit at N+9.
- Byte duration is 8 cycles plus one per inserted 0.
- The closing flag occupies the 8 cycles immediately after the last data or stuff bit.
- Tx_ValidFrame falls in the cycle after the last closing-flag bit, coincident with Tx_Done.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package hdlc_pkg holds:
  - constants HDLC_FLAG=8'h7E and HDLC_ABORT=8'hFE (LSB-first 0,1×7);
  - the state enum tx_state_t {IDLE, OPEN, DATA, CLOSE, ABORT}.
- Sub-module hdlc_zero_inserter contains the ones counter, the stuff decision and the hold signal. It has clear and enable inputs and is reusable for counter checks on the Rx side.
- The top level contains the FSM, the 8-bit shift register, the bit counter (3 bits) and the flag counter (2 bits).

## Test plan
- Single byte 0xA5, Last=1 → Tx: 0,1,1,1,1,1,1,0 | 1,0,1,0,0,1,0,1 | 0,1,1,1,1,1,1,0. No stuffing; Tx_Done pulses once.
- Single byte 0xFF, Last=1 → data field 1,1,1,1,1,0,1,1,1 (9 bits) between flags. Frame is 25 Tx_ValidFrame cycles.
- Bytes 0x7E, 0x01 → data field 0,1,1,1,1,1,0,1,0 then 1,0,0,0,0,0,0,0. The flag value in the payload must never appear unstuffed.
- Tx_AbortFrame asserted during bit 3 of the second byte → one more bit, then 0,1,1,1,1,1,1,1. Tx_AbortedTrans pulses once, Tx_ValidFrame falls with it, and Tx is 1 afterwards.
- Underflow: first byte Last=0 and Tx_DataValid low at the Tx_DataReady cycle → abort pattern with no closing flag.
- Rst low mid-DATA → Tx=1 and all other outputs 0 in the same cycle. A new frame after release starts with an opening flag and the ones counter at 0.
